ps2_scancode_receiver: RTL and testbench
========================================

// Module: ps2_scancode_receiver
// PURPOSE
//  Upstream stage of the keyboard path. Deserialises PS/2 device-to-host frames and strips the E0 (extended) and F0 (break) prefixes.
//  Emits one final scancode per key event, with its flags, as a single-cycle data_ready strobe.
//  Feeds the keyboard adapter / scancode-to-ASCII stage; receive-only, never drives the PS/2 lines.
// PARAMETERS
//  FILTER_LEN      8      consecutive equal ps2clk samples required before the filtered clock changes
//  TIMEOUT_CYCLES  10000  clk cycles without a ps2clk falling edge mid-frame before the frame is aborted (200us @50MHz)
// PORTS
//  clk         in   1  system clock, sole clock domain
//  rst         in   1  asynchronous, active-low reset
//  ps2clk      in   1  raw PS/2 clock, asynchronous, idles high
//  ps2data     in   1  raw PS/2 data, asynchronous, idles high
//  data_ready  out  1  one-cycle strobe: out/e0_flag/break_flag are valid for a new key event
//  e0_flag     out  1  key event was preceded by an E0 prefix
//  break_flag  out  1  key event was preceded by an F0 prefix (key release)
//  out         out  8  final scancode byte; held until the next event
//  frame_err   out  1  one-cycle strobe on parity, stop-bit or timeout error
// BEHAVIOUR
//  Reset (rst=0, async):
//   - data_ready, e0_flag, break_flag, out, frame_err all 0.
//   - FSM to IDLE; prefix-pending bits cleared.
//   - Synchroniser and filter registers preset to 1 (line idle), so no false edge at reset release.
//  Input conditioning:
//   - ps2clk and ps2data each pass through a 2-FF synchroniser.
//   - Filtered clock changes only after FILTER_LEN equal synchronised samples.
//   - fall = filtered clock 1->0; one-cycle pulse. ps2data (synchronised) is sampled on fall.
//  FSM, advances only on fall except for timeout:
//   - IDLE: data=0 -> DATA, bitcnt=0. data=1 -> stay IDLE, no error.
//   - DATA: shift right, sample into sh[7], LSB first. After 8th bit -> PARITY.
//   - PARITY: ok = (^sh ^ bit) == 1 (odd parity). Stores ok, -> STOP.
//   - STOP: bit=1 && ok -> accept byte. Otherwise error. Either way -> IDLE.
//  Accept rules:
//   - byte==8'hE0: set e0_pend, no strobe.
//   - byte==8'hF0: set f0_pend, no strobe.
//   - Any other byte (incl. E1): out<=byte, e0_flag<=e0_pend, break_flag<=f0_pend, data_ready=1 for exactly one cycle, both pends cleared.
//   - e0_flag, break_flag and out hold until the next accepted event.
//  Error: frame_err=1 for one cycle; pends cleared; no data_ready; out/flags unchanged.
//  Timeout:
//   - Cycle counter clears on every fall and is held at 0 in IDLE.
//   - Counter==TIMEOUT_CYCLES-1 outside IDLE -> IDLE, frame_err strobe, pends cleared.
//   - Counter saturates; it never wraps.
//  Latency: data_ready/frame_err asserted on the clk edge after the fall that samples the stop bit.
//  Simultaneous: a timeout and a fall in the same cycle resolve as a fall (counter cleared); the timeout is not taken.
//  data_ready and frame_err are never high together.
//  Reset mid-frame discards the partial frame and the pends; the next full frame decodes normally.
// STRUCTURE
//  Shared package ps2_pkg:
//   - PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BREAK=8'hF0
//   - 2-bit state encoding IDLE/DATA/PARITY/STOP
//  Sub-module ps2_line_filter:
//   - 2-FF sync + FILTER_LEN glitch filter + falling-edge pulse.
//   - Instanced for ps2clk; ps2data uses its synchronised output only.
//  Top holds the FSM, shift register, bit counter, timeout counter and prefix/output registers.
// TESTING
//  - Frame 0x1C, ~80us bit period -> one data_ready, out=8'h1C, e0=0, break=0, frame_err never set.
//  - Frames F0,1C -> no strobe after F0; one strobe after 1C, out=8'h1C, break=1, e0=0.
//  - Frames E0,F0,75 -> single strobe after 75, out=8'h75, e0=1, break=1; next frame 75 alone -> e0=0, break=0.
//  - Frame 0x1C, parity flipped -> frame_err pulse, no data_ready, out unchanged; then F0 (good), 1C (bad stop), 1C (good) -> out=8'h1C, break=0.
//  - 4 bits, then clock held high TIMEOUT_CYCLES+10 -> one frame_err, FSM IDLE; following 0x2A decodes to out=8'h2A.
//  - 3-cycle low glitch on ps2clk mid-frame -> no extra bit, frame decodes correctly. rst=0 after 5 bits of a frame -> all outputs 0; next 0x1C decodes.

Source files
------------

// File: rtl/ps2_scancode_receiver_pkg.sv
// Shared definitions for the PS/2 receive path: prefix byte values and FSM state encoding.
package ps2_pkg;

   localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_e;

endpackage

// File: rtl/ps2_scancode_receiver_if.sv
// PS/2 line inputs and key-event outputs of the scancode receiver.
interface ps2_scancode_receiver_if;
   logic       ps2clk;
   logic       ps2data;
   logic       data_ready;
   logic       e0_flag;
   logic       break_flag;
   logic [7:0] out;
   logic       frame_err;

   modport master (
      output ps2clk, ps2data,
      input  data_ready, e0_flag, break_flag, out, frame_err
   );

   modport slave (
      input  ps2clk, ps2data,
      output data_ready, e0_flag, break_flag, out, frame_err
   );
endinterface

// File: rtl/ps2_scancode_receiver_line_filter.sv
// 2-FF synchroniser, glitch filter and falling-edge pulse for the raw PS/2 clock line.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic line_in,
   output logic fall
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(FILTER_LEN - 1);

   logic          sync1_q, sync2_q;
   logic          filt_d, filt_q;
   logic [CW-1:0] cnt_d, cnt_q;
   logic          fall_d, fall_q;

   // Filtered level flips once the synchronised input has disagreed for FILTER_LEN samples in a row.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = cnt_q;
      fall_d = 1'b0;
      if (sync2_q == filt_q) begin
         cnt_d = CNT_LOAD;
      end else if (cnt_q == '0) begin
         filt_d = sync2_q;
         cnt_d  = CNT_LOAD;
         fall_d = filt_q & ~sync2_q;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         filt_q  <= 1'b1;
         cnt_q   <= CNT_LOAD;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= line_in;
         sync2_q <= sync1_q;
         filt_q  <= filt_d;
         cnt_q   <= cnt_d;
         fall_q  <= fall_d;
      end
   end

   assign fall = fall_q;

endmodule

// File: rtl/ps2_scancode_receiver.sv
// PS/2 device-to-host frame receiver; folds E0/F0 prefixes into flags on the final scancode.
//  state     | meaning
//  ST_IDLE   | waiting for a start bit (data low on a clock fall)
//  ST_DATA   | shifting in 8 data bits, LSB first
//  ST_PARITY | checking odd parity over data + parity bit
//  ST_STOP   | checking stop bit, then accept or flag an error
module ps2_scancode_receiver
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic                    clk,
   input  logic                    rst,
   ps2_scancode_receiver_if.slave  bus
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic          fall;
   logic          dsync1_q, dsync2_q;

   ps2_state_e    state_d, state_q;
   logic [7:0]    sh_d, sh_q;
   logic [2:0]    bitcnt_d, bitcnt_q;
   logic          ok_d, ok_q;
   logic [TW-1:0] to_cnt_d, to_cnt_q;
   logic          e0_pend_d, e0_pend_q;
   logic          f0_pend_d, f0_pend_q;
   logic [7:0]    out_d, out_q;
   logic          e0_flag_d, e0_flag_q;
   logic          break_flag_d, break_flag_q;
   logic          data_ready_d, data_ready_q;
   logic          frame_err_d, frame_err_q;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk     (clk),
      .rst_n   (rst),
      .line_in (bus.ps2clk),
      .fall    (fall)
   );

   // Data only needs synchronising: it is sampled well after the filtered clock settles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dsync1_q <= 1'b1;
         dsync2_q <= 1'b1;
      end else begin
         dsync1_q <= bus.ps2data;
         dsync2_q <= dsync1_q;
      end
   end

   always_comb begin
      state_d      = state_q;
      sh_d         = sh_q;
      bitcnt_d     = bitcnt_q;
      ok_d         = ok_q;
      to_cnt_d     = to_cnt_q;
      e0_pend_d    = e0_pend_q;
      f0_pend_d    = f0_pend_q;
      out_d        = out_q;
      e0_flag_d    = e0_flag_q;
      break_flag_d = break_flag_q;
      data_ready_d = 1'b0;
      frame_err_d  = 1'b0;

      // A fall always wins over a timeout landing in the same cycle.
      if (state_q == ST_IDLE || fall) begin
         to_cnt_d = '0;
      end else if (to_cnt_q == TO_LAST) begin
         state_d     = ST_IDLE;
         frame_err_d = 1'b1;
         e0_pend_d   = 1'b0;
         f0_pend_d   = 1'b0;
         to_cnt_d    = '0;
      end else begin
         to_cnt_d = to_cnt_q + 1'b1;
      end

      if (fall) begin
         unique case (state_q)
            ST_IDLE: begin
               if (!dsync2_q) begin
                  state_d  = ST_DATA;
                  bitcnt_d = '0;
               end
            end
            ST_DATA: begin
               sh_d     = {dsync2_q, sh_q[7:1]};
               bitcnt_d = bitcnt_q + 1'b1;
               if (bitcnt_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: begin
               ok_d    = (^sh_q) ^ dsync2_q;
               state_d = ST_STOP;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if (dsync2_q && ok_q) begin
                  if (sh_q == PS2_PREFIX_EXT) begin
                     e0_pend_d = 1'b1;
                  end else if (sh_q == PS2_PREFIX_BREAK) begin
                     f0_pend_d = 1'b1;
                  end else begin
                     out_d        = sh_q;
                     e0_flag_d    = e0_pend_q;
                     break_flag_d = f0_pend_q;
                     data_ready_d = 1'b1;
                     e0_pend_d    = 1'b0;
                     f0_pend_d    = 1'b0;
                  end
               end else begin
                  frame_err_d = 1'b1;
                  e0_pend_d   = 1'b0;
                  f0_pend_d   = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         sh_q         <= '0;
         bitcnt_q     <= '0;
         ok_q         <= 1'b0;
         to_cnt_q     <= '0;
         e0_pend_q    <= 1'b0;
         f0_pend_q    <= 1'b0;
         out_q        <= '0;
         e0_flag_q    <= 1'b0;
         break_flag_q <= 1'b0;
         data_ready_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         sh_q         <= sh_d;
         bitcnt_q     <= bitcnt_d;
         ok_q         <= ok_d;
         to_cnt_q     <= to_cnt_d;
         e0_pend_q    <= e0_pend_d;
         f0_pend_q    <= f0_pend_d;
         out_q        <= out_d;
         e0_flag_q    <= e0_flag_d;
         break_flag_q <= break_flag_d;
         data_ready_q <= data_ready_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign bus.data_ready = data_ready_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.out        = out_q;
   assign bus.e0_flag    = e0_flag_q;
   assign bus.break_flag = break_flag_q;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Directed bench for the PS/2 scancode receiver: prefixes, errors, timeout, glitch, mid-frame reset.
module tb_ps2_scancode_receiver;
   import ps2_pkg::*;

   localparam int FLT  = 8;
   localparam int TO   = 400;
   localparam int HALF = 40;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   dr_cnt = 0;
   int   fe_cnt = 0;
   int   both_cnt = 0;
   int   dr0, fe0;

   ps2_scancode_receiver_if bus ();

   ps2_scancode_receiver #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.data_ready) dr_cnt++;
      if (bus.frame_err)  fe_cnt++;
      if (bus.data_ready && bus.frame_err) both_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic send_bit(input logic b, input logic glitch);
      bus.ps2data = b;
      wait_clk(HALF);
      bus.ps2clk = 1'b0;
      wait_clk(HALF);
      bus.ps2clk = 1'b1;
      if (glitch) begin
         wait_clk(5);
         bus.ps2clk = 1'b0;
         wait_clk(3);
         bus.ps2clk = 1'b1;
      end
   endtask

   // nbits limits how many of the 11 frame bits are sent; glitch_at selects a bit followed by a short low pulse.
   task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop,
                             input int nbits, input int glitch_at);
      logic [10:0] f;
      f = {stop, (~^b) ^ flip_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) send_bit(f[i], i == glitch_at);
      bus.ps2data = 1'b1;
      if (nbits == 11) wait_clk(2 * HALF);
   endtask

   task automatic good(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b1, 11, -1);
   endtask

   task automatic mark;
      dr0 = dr_cnt;
      fe0 = fe_cnt;
   endtask

   initial begin
      bus.ps2clk  = 1'b1;
      bus.ps2data = 1'b1;
      wait_clk(5);
      @(negedge clk);
      chk("rst_dr",  {31'd0, bus.data_ready}, 0);
      chk("rst_fe",  {31'd0, bus.frame_err},  0);
      chk("rst_out", {24'd0, bus.out},        0);
      chk("rst_e0",  {31'd0, bus.e0_flag},    0);
      chk("rst_brk", {31'd0, bus.break_flag}, 0);
      rst = 1'b1;
      wait_clk(20);

      mark(); good(8'h1C); @(negedge clk);
      chk("m1_dr",  dr_cnt - dr0, 1);
      chk("m1_fe",  fe_cnt - fe0, 0);
      chk("m1_out", {24'd0, bus.out}, 32'h1C);
      chk("m1_e0",  {31'd0, bus.e0_flag}, 0);
      chk("m1_brk", {31'd0, bus.break_flag}, 0);

      mark(); good(8'hF0); @(negedge clk);
      chk("f0_nodr", dr_cnt - dr0, 0);
      good(8'h1C); @(negedge clk);
      chk("brk_dr",  dr_cnt - dr0, 1);
      chk("brk_out", {24'd0, bus.out}, 32'h1C);
      chk("brk_brk", {31'd0, bus.break_flag}, 1);
      chk("brk_e0",  {31'd0, bus.e0_flag}, 0);

      mark(); good(8'hE0); good(8'hF0); @(negedge clk);
      chk("ext_nodr", dr_cnt - dr0, 0);
      good(8'h75); @(negedge clk);
      chk("ext_dr",  dr_cnt - dr0, 1);
      chk("ext_out", {24'd0, bus.out}, 32'h75);
      chk("ext_e0",  {31'd0, bus.e0_flag}, 1);
      chk("ext_brk", {31'd0, bus.break_flag}, 1);
      good(8'h75); @(negedge clk);
      chk("plain_e0",  {31'd0, bus.e0_flag}, 0);
      chk("plain_brk", {31'd0, bus.break_flag}, 0);
      chk("plain_dr",  dr_cnt - dr0, 2);

      mark(); send_frame(8'h1C, 1'b1, 1'b1, 11, -1); @(negedge clk);
      chk("par_fe",  fe_cnt - fe0, 1);
      chk("par_dr",  dr_cnt - dr0, 0);
      chk("par_out", {24'd0, bus.out}, 32'h75);
      mark();
      good(8'hF0);
      send_frame(8'h1C, 1'b0, 1'b0, 11, -1);
      good(8'h1C); @(negedge clk);
      chk("stop_fe",  fe_cnt - fe0, 1);
      chk("stop_dr",  dr_cnt - dr0, 1);
      chk("stop_out", {24'd0, bus.out}, 32'h1C);
      chk("stop_brk", {31'd0, bus.break_flag}, 0);

      mark(); send_frame(8'h55, 1'b0, 1'b1, 4, -1);
      wait_clk(TO + 10); @(negedge clk);
      chk("to_fe",   fe_cnt - fe0, 1);
      chk("to_dr",   dr_cnt - dr0, 0);
      chk("to_idle", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
      good(8'h2A); @(negedge clk);
      chk("to_out", {24'd0, bus.out}, 32'h2A);
      chk("to_dr2", dr_cnt - dr0, 1);

      mark(); send_frame(8'h4B, 1'b0, 1'b1, 11, 4); @(negedge clk);
      chk("gl_dr",  dr_cnt - dr0, 1);
      chk("gl_fe",  fe_cnt - fe0, 0);
      chk("gl_out", {24'd0, bus.out}, 32'h4B);

      send_frame(8'hE0, 1'b0, 1'b1, 11, -1);
      send_frame(8'h33, 1'b0, 1'b1, 5, -1);
      rst = 1'b0;
      wait_clk(3); @(negedge clk);
      chk("mr_out", {24'd0, bus.out}, 0);
      chk("mr_dr",  {31'd0, bus.data_ready}, 0);
      chk("mr_fe",  {31'd0, bus.frame_err}, 0);
      chk("mr_e0",  {31'd0, bus.e0_flag}, 0);
      chk("mr_brk", {31'd0, bus.break_flag}, 0);
      rst = 1'b1;
      wait_clk(20);
      mark(); good(8'h1C); @(negedge clk);
      chk("mr2_dr",  dr_cnt - dr0, 1);
      chk("mr2_fe",  fe_cnt - fe0, 0);
      chk("mr2_out", {24'd0, bus.out}, 32'h1C);
      chk("mr2_e0",  {31'd0, bus.e0_flag}, 0);

      chk("never_both", both_cnt, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
